inst_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of imem2048. Owns the program counter and drives imem pc_i.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/inst_fetch_unit.sv | 108 ++++++++++
 tb/tb_inst_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fetch_pkg;

  // Native PC width; the fetch entry layout is built around it.
  localparam int FETCH_XLEN = 64;
  // imem word width.
  localparam int INSTR_W    = 32;
  // Byte distance between sequential fetches.
  localparam int PC_STEP    = 4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so the result is word aligned.
  function automatic logic [FETCH_XLEN-1:0] align_word(input logic [FETCH_XLEN-1:0] addr);
    return addr & ~FETCH_XLEN'(PC_STEP - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous queue of fetch entries with a single-cycle flush.
// Latency: a pushed entry becomes visible at the head one cycle later (no bypass).
// Backpressure: head held stable until popped; the writer is expected never to push while full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_dat_i,
  input  logic          pop_i,
  output logic          head_vld_o,
  output fetch_entry_t  head_dat_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop frees the slot the same cycle, so full + pop + push is accepted.
  assign w_do_pop  = pop_i & ~w_empty;
  assign w_do_push = push_i & (~w_full | w_do_pop);

  // Pointer and occupancy bookkeeping; flush simply rewinds everything.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; never read while empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_dat_i;
    end
  end

  // Head is forced to zero when empty so downstream never sees stale data.
  assign head_vld_o = ~w_empty;
  assign head_dat_o = w_empty ? fetch_entry_t'('0) : r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign full_o     = w_full;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads and queues {pc, instr} pairs for decode.
// Latency: first instr_valid_o two cycles after the first imem request; then one per cycle.
// Backpressure: issue stalls once queued + in-flight entries reach DEPTH; the head holds while !ready.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  // Must equal FETCH_XLEN: queue entries are laid out from the package type.
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            fetch_en_i,
  output logic            imem_req_o,
  output logic [31:0]     imem_pc_o,
  input  logic [31:0]     imem_instr_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occupancy;
  logic            w_full;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_head_vld;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;

  // Slots already spoken for: entries queued plus the response still on its way.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

  // Issue only when the returning word is guaranteed a queue slot; a redirect
  // cycle never issues because r_pc is about to be replaced. Reset masks the
  // request so imem sees nothing while the stage is being initialised.
  assign w_issue = ~reset_i & fetch_en_i & ~redirect_i & (w_occupancy < DEPTH_C);

  assign imem_req_o = w_issue;
  assign imem_pc_o  = r_pc[31:0];

  // The imem word arriving now belongs to last cycle's request; a redirect discards it.
  assign w_push     = r_inflight & ~redirect_i;
  assign w_push_dat = '{pc: r_inflight_pc, instr: imem_instr_i};

  // Decode's handshake completes even in a redirect cycle; the flush follows it.
  assign w_pop = w_head_vld & instr_ready_i;

  // PC and in-flight tracking; reset beats redirect, redirect beats sequential fetch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_i) begin
      r_pc       <= align_word(redirect_pc_i);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + XLEN'(PC_STEP);
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (redirect_i),
    .push_i     (w_push),
    .push_dat_i (w_push_dat),
    .pop_i      (w_pop),
    .head_vld_o (w_head_vld),
    .head_dat_o (w_head),
    .count_o    (w_count),
    .full_o     (w_full)
  );

  assign instr_valid_o = w_head_vld;
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;

  // Credit accounting must keep pushes off a full queue and pops off an empty one.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(w_push && w_full && !w_pop))
        else $error("inst_fetch_unit: push into full fetch queue");
      assert (!(w_pop && !w_head_vld))
        else $error("inst_fetch_unit: pop from empty fetch queue");
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural 512-word imem and an in-order scoreboard.
// Latency: models imem as a one-cycle registered read of the requested word.
// Backpressure: drives instr_ready_i directly from the stimulus sequence.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            fetch_en_i;
  logic            imem_req_o;
  logic [31:0]     imem_pc_o;
  logic [31:0]     imem_instr_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (64'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .fetch_en_i    (fetch_en_i),
    .imem_req_o    (imem_req_o),
    .imem_pc_o     (imem_pc_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  // imem: word read registered on the clock, valid the cycle after the address.
  logic [31:0] mem [0:511];
  always @(posedge clk) imem_instr_i <= mem[imem_pc_o[10:2]];

  fetch_entry_t    exp_q[$];
  logic [XLEN-1:0] gen_pc;
  int              n_cmp = 0;
  int              n_mis = 0;
  int              n_pop = 0;
  int              p0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_mis++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One clock: score a handshake at the falling edge, then track flushes and
  // extend the expected stream at the rising edge, returning 1 time unit after it.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    if (!reset_i && instr_valid_o && instr_ready_i) begin
      e = exp_q.pop_front();
      chk("pop_pc", instr_pc_o, e.pc);
      chk("pop_instr", {32'h0, instr_o}, {32'h0, e.instr});
      n_pop++;
    end
    @(posedge clk);
    if (reset_i) begin
      exp_q.delete();
      gen_pc = 64'h0;
    end else if (redirect_i) begin
      exp_q.delete();
      gen_pc = redirect_pc_i & ~64'h3;
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: gen_pc, instr: mem[gen_pc[10:2]]});
      gen_pc += 64'd4;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    reset_i       = 1'b1;
    fetch_en_i    = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b1;
    gen_pc        = '0;

    // 1: reset, then sequential fetch from 0
    repeat (3) tick();
    chk("rst_req", imem_req_o, 0);
    chk("rst_vld", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_ipc", instr_pc_o, 0);
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t1_req", imem_req_o, 1);
      chk("t1_pc", imem_pc_o, 4 * c);
      chk("t1_vld", instr_valid_o, (c == 2));
      tick();
    end
    repeat (12) begin
      #1;
      chk("t1_stream_vld", instr_valid_o, 1);
      tick();
    end

    // 2: backpressure fills exactly DEPTH entries and holds the head
    instr_ready_i = 1'b0;
    repeat (10) begin
      #1;
      chk("t2_vld", instr_valid_o, 1);
      chk("t2_head_pc", instr_pc_o, exp_q[0].pc);
      chk("t2_head_instr", instr_o, exp_q[0].instr);
      tick();
    end
    #1;
    chk("t2_req_stalled", imem_req_o, 0);
    fetch_en_i    = 1'b0;
    instr_ready_i = 1'b1;
    p0 = n_pop;
    repeat (8) tick();
    chk("t2_buffered", n_pop - p0, DEPTH);
    fetch_en_i = 1'b1;
    repeat (6) tick();

    // 3: redirect to 0x40 while queue holds 0x10..0x1C
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    p0 = n_pop;
    for (int k = 0; k < 20 && (n_pop - p0) < 4; k++) tick();
    chk("t3_drained4", n_pop - p0, 4);
    instr_ready_i = 1'b0;
    repeat (6) tick();
    #1;
    chk("t3_head_pc", instr_pc_o, 64'h10);
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h40;
    #1;
    chk("t3_redir_noreq", imem_req_o, 0);
    tick();
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    chk("t3_req", imem_req_o, 1);
    chk("t3_pc40", imem_pc_o, 32'h40);
    chk("t3_vld_n1", instr_valid_o, 0);
    tick();
    #1;
    chk("t3_vld_n2", instr_valid_o, 0);
    chk("t3_pc44", imem_pc_o, 32'h44);
    tick();
    #1;
    chk("t3_vld_n3", instr_valid_o, 1);
    chk("t3_ipc", instr_pc_o, 64'h40);
    chk("t3_instr", instr_o, mem[16]);
    repeat (6) tick();

    // 4a: misaligned target is word aligned
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h43;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t4a_req", imem_req_o, 1);
    chk("t4a_pc", imem_pc_o, 32'h40);
    repeat (4) tick();

    // 4b: back-to-back redirects, last one wins
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h80;
    tick();
    redirect_pc_i = 64'hC0;
    #1;
    chk("t4b_noreq", imem_req_o, 0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t4b_req", imem_req_o, 1);
    chk("t4b_pc", imem_pc_o, 32'hC0);
    tick();
    #1;
    chk("t4b_vld_n2", instr_valid_o, 0);
    tick();
    #1;
    chk("t4b_vld_n3", instr_valid_o, 1);
    chk("t4b_ipc", instr_pc_o, 64'hC0);
    repeat (4) tick();

    // 4c: redirect coincident with a pop
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h100;
    #1;
    chk("t4c_vld_at_redir", instr_valid_o, 1);
    p0 = n_pop;
    tick();
    chk("t4c_one_pop", n_pop - p0, 1);
    redirect_i = 1'b0;
    #1;
    chk("t4c_vld_n1", instr_valid_o, 0);
    tick();
    #1;
    chk("t4c_vld_n2", instr_valid_o, 0);
    tick();
    #1;
    chk("t4c_ipc", instr_pc_o, 64'h100);
    repeat (4) tick();

    // 5: fetch_en toggling with random ready
    p0 = n_pop;
    for (int k = 0; k < 60; k++) begin
      fetch_en_i    = ((k / 3) % 2 == 0);
      instr_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    fetch_en_i    = 1'b1;
    instr_ready_i = 1'b1;
    repeat (10) tick();
    chk("t5_progress", (n_pop - p0) >= 10, 1);

    // 6: reset with the queue full
    instr_ready_i = 1'b0;
    repeat (8) tick();
    #1;
    chk("t6_full_vld", instr_valid_o, 1);
    chk("t6_full_noreq", imem_req_o, 0);
    reset_i = 1'b1;
    tick();
    #1;
    chk("t6_req", imem_req_o, 0);
    chk("t6_vld", instr_valid_o, 0);
    chk("t6_instr", instr_o, 0);
    chk("t6_ipc", instr_pc_o, 0);
    chk("t6_imem_pc", imem_pc_o, 0);
    reset_i       = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    chk("t6_restart_req", imem_req_o, 1);
    chk("t6_restart_pc", imem_pc_o, 0);
    tick();
    tick();
    #1;
    chk("t6_first_vld", instr_valid_o, 1);
    chk("t6_first_ipc", instr_pc_o, 0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
